fb_text_writer: RTL and testbench



---
 rtl/fb_text_pkg.sv | 12 +
 rtl/fb_fill_seq.sv | 37 +++
 rtl/fb_text_writer.sv | 126 ++++++++++++
 tb/tb_fb_text_writer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fb_text_pkg.sv
// fb_text_pkg: geometry, character codes and FSM states for the text framebuffer writer
package fb_text_pkg;
  localparam int COLS = 98;
  localparam int ROWS = 35;
  localparam int FB_ADDR_W = 12;
  localparam int FB_CELLS = COLS * ROWS;
  localparam logic [7:0] BLANK_CHAR = 8'h00;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  typedef enum logic [2:0] {INIT_CLR, IDLE, PUT, LINE_CLR, SCREEN_CLR} state_t;
endpackage

// File: rtl/fb_fill_seq.sv
// fb_fill_seq: emits count ascending writes of din from base, one per cycle, with a done pulse
module fb_fill_seq
  import fb_text_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [FB_ADDR_W-1:0] base,
  input  logic [FB_ADDR_W-1:0] count,
  input  logic [7:0]           din,
  output logic [FB_ADDR_W-1:0] addr,
  output logic [7:0]           data,
  output logic                 we,
  output logic                 done
);
  logic [FB_ADDR_W-1:0] rem;
  assign done = we && rem == '0;
  // start wins over done so a new run can follow the last write with no gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      data <= '0;
      we   <= 1'b0;
      rem  <= '0;
    end else if (start) begin
      addr <= base;
      data <= din;
      we   <= 1'b1;
      rem  <= count - 1'b1;
    end else if (done) begin
      we <= 1'b0;
    end else if (we) begin
      addr <= addr + 1'b1;
      rem  <= rem - 1'b1;
    end
  end
endmodule

// File: rtl/fb_text_writer.sv
// fb_text_writer: ASCII stream to text framebuffer writes with cursor, wrap and clearing
module fb_text_writer
  import fb_text_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           char_data,
  input  logic                 char_valid,
  output logic                 char_ready,
  input  logic                 clear_req,
  output logic [7:0]           framebuffer_data,
  output logic [FB_ADDR_W-1:0] framebuffer_addr,
  output logic                 framebuffer_write_enable,
  output logic [6:0]           cursor_col,
  output logic [5:0]           cursor_row,
  output logic                 busy
);
  state_t state;
  logic [FB_ADDR_W-1:0] row_base, nxt_base, cur_addr, fill_base, fill_count;
  logic [7:0] fill_data;
  logic [5:0] nxt_row;
  logic clr_pend, wrap, fill_start, fill_done, do_clr, accept, printable;
  assign nxt_row    = cursor_row == 6'(ROWS - 1) ? '0 : cursor_row + 6'd1;
  assign nxt_base   = cursor_row == 6'(ROWS - 1) ? '0 : row_base + FB_ADDR_W'(COLS);
  assign cur_addr   = row_base + FB_ADDR_W'(cursor_col);
  assign do_clr     = state == IDLE && (clear_req || clr_pend);
  assign char_ready = state == IDLE && !clear_req && !clr_pend;
  assign accept     = char_valid && char_ready;
  assign printable  = char_data != CH_LF && char_data != CH_CR && char_data != CH_BS;
  always_comb begin
    fill_start = 1'b1;
    fill_base  = '0;
    fill_count = FB_ADDR_W'(1);
    fill_data  = BLANK_CHAR;
    if (do_clr || (state == INIT_CLR && !framebuffer_write_enable))
      fill_count = FB_ADDR_W'(FB_CELLS);
    else if (accept && char_data == CH_LF) begin
      fill_base  = nxt_base;
      fill_count = FB_ADDR_W'(COLS);
    end else if (accept && char_data == CH_BS && cursor_col != '0)
      fill_base = cur_addr - 1'b1;
    else if (accept && printable) begin
      fill_base = cur_addr;
      fill_data = char_data;
    end else if (state == PUT && fill_done && wrap) begin
      fill_base  = row_base;
      fill_count = FB_ADDR_W'(COLS);
    end else
      fill_start = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT_CLR;
      busy       <= 1'b1;
      cursor_col <= '0;
      cursor_row <= '0;
      row_base   <= '0;
      clr_pend   <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      if (clear_req && state != IDLE) clr_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (do_clr) begin
            state    <= SCREEN_CLR;
            busy     <= 1'b1;
            clr_pend <= 1'b0;
          end else if (accept) begin
            if (char_data == CH_CR) cursor_col <= '0;
            else if (char_data == CH_LF) begin
              cursor_col <= '0;
              cursor_row <= nxt_row;
              row_base   <= nxt_base;
              state      <= LINE_CLR;
              busy       <= 1'b1;
            end else if (char_data == CH_BS) begin
              if (cursor_col != '0) begin
                cursor_col <= cursor_col - 7'd1;
                wrap       <= 1'b0;
                state      <= PUT;
                busy       <= 1'b1;
              end
            end else begin
              wrap  <= cursor_col == 7'(COLS - 1);
              state <= PUT;
              busy  <= 1'b1;
              if (cursor_col == 7'(COLS - 1)) begin
                cursor_col <= '0;
                cursor_row <= nxt_row;
                row_base   <= nxt_base;
              end else
                cursor_col <= cursor_col + 7'd1;
            end
          end
        end
        PUT: if (fill_done) begin
          state <= wrap ? LINE_CLR : IDLE;
          busy  <= wrap;
        end
        LINE_CLR: if (fill_done) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: if (fill_done) begin
          state      <= IDLE;
          busy       <= 1'b0;
          cursor_col <= '0;
          cursor_row <= '0;
          row_base   <= '0;
        end
      endcase
    end
  end
  fb_fill_seq u_fill (
    .clk   (clk),
    .rst_n (rst_n),
    .start (fill_start),
    .base  (fill_base),
    .count (fill_count),
    .din   (fill_data),
    .addr  (framebuffer_addr),
    .data  (framebuffer_data),
    .we    (framebuffer_write_enable),
    .done  (fill_done)
  );
endmodule

// File: tb/tb_fb_text_writer.sv
// tb_fb_text_writer: scoreboard bench, expected writes queued at stimulus and popped per write strobe
module tb_fb_text_writer;
  localparam int NC = 98;
  localparam int NR = 35;
  typedef struct { int a; int d; } wr_t;
  logic clk = 0, rst_n = 0;
  logic [7:0] char_data = '0;
  logic char_valid = 0, clear_req = 0;
  logic char_ready, framebuffer_write_enable, busy;
  logic [7:0] framebuffer_data;
  logic [11:0] framebuffer_addr;
  logic [6:0] cursor_col;
  logic [5:0] cursor_row;
  wr_t q[$];
  wr_t exp_w;
  int n_tests = 0, n_fail = 0, cyc = 0;
  int m_col = 0, m_row = 0;
  int ta, tb;
  fb_text_writer dut (
    .clk(clk), .rst_n(rst_n), .char_data(char_data), .char_valid(char_valid),
    .char_ready(char_ready), .clear_req(clear_req), .framebuffer_data(framebuffer_data),
    .framebuffer_addr(framebuffer_addr), .framebuffer_write_enable(framebuffer_write_enable),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (rst_n && framebuffer_write_enable) begin
    if (q.size() == 0) check("extra_write", int'(framebuffer_addr), -1);
    else begin
      exp_w = q.pop_front();
      check("wr_addr", int'(framebuffer_addr), exp_w.a);
      check("wr_data", int'(framebuffer_data), exp_w.d);
    end
  end
  task automatic push(input int a, input int d);
    wr_t w;
    w.a = a;
    w.d = d;
    q.push_back(w);
  endtask
  task automatic push_line(input int r);
    for (int c = 0; c < NC; c++) push(r * NC + c, 0);
  endtask
  task automatic push_screen();
    for (int a = 0; a < NC * NR; a++) push(a, 0);
    m_col = 0;
    m_row = 0;
  endtask
  task automatic adv();
    m_row = (m_row == NR - 1) ? 0 : m_row + 1;
  endtask
  task automatic model(input logic [7:0] c);
    if (c == 8'h0D) m_col = 0;
    else if (c == 8'h0A) begin m_col = 0; adv(); push_line(m_row); end
    else if (c == 8'h08) begin
      if (m_col > 0) begin m_col--; push(m_row * NC + m_col, 0); end
    end else begin
      push(m_row * NC + m_col, int'(c));
      m_col++;
      if (m_col == NC) begin m_col = 0; adv(); push_line(m_row); end
    end
  endtask
  task automatic send(input logic [7:0] c, output int t);
    int n = 0;
    @(negedge clk);
    while (!char_ready && n < 8000) begin @(negedge clk); n++; end
    check("ready_wait", int'(char_ready), 1);
    model(c);
    t = cyc;
    char_data = c;
    char_valid = 1;
    @(posedge clk);
    #1 char_valid = 0;
  endtask
  task automatic send_n(input logic [7:0] c, input int k);
    int t;
    for (int i = 0; i < k; i++) send(c, t);
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy || q.size() != 0) && n < 8000);
    check("drain", q.size(), 0);
    check("idle", int'(busy), 0);
  endtask
  task automatic chk_cursor(input string tag, input int c, input int r);
    check({tag, "_col"}, int'(cursor_col), c);
    check({tag, "_row"}, int'(cursor_row), r);
  endtask
  initial begin
    int t;
    repeat (3) @(negedge clk);
    check("rst_we", int'(framebuffer_write_enable), 0);
    check("rst_addr", int'(framebuffer_addr), 0);
    check("rst_data", int'(framebuffer_data), 0);
    check("rst_ready", int'(char_ready), 0);
    check("rst_busy", int'(busy), 1);
    chk_cursor("rst", 0, 0);
    push_screen();
    rst_n = 1;
    wait_idle();
    check("init_ready", int'(char_ready), 1);
    chk_cursor("init", 0, 0);
    send(8'h41, ta);
    send(8'h42, tb);
    check("ab_spacing", tb - ta, 2);
    wait_idle();
    chk_cursor("ab", 2, 0);
    send(8'h0D, t);
    send_n(8'h78, NC);
    wait_idle();
    chk_cursor("row_wrap", 0, 1);
    send_n(8'h0A, 33);
    send_n(8'h79, 5);
    wait_idle();
    chk_cursor("pre_lf", 5, 34);
    send(8'h0A, t);
    wait_idle();
    chk_cursor("lf_wrap", 0, 0);
    send_n(8'h0A, 2);
    send(8'h61, t);
    send(8'h62, t);
    send(8'h63, t);
    send(8'h08, t);
    wait_idle();
    chk_cursor("bs", 2, 2);
    send(8'h0D, t);
    @(negedge clk);
    check("cr_ready", int'(char_ready), 1);
    send(8'h08, t);
    wait_idle();
    chk_cursor("bs0", 0, 2);
    @(negedge clk);
    clear_req = 1;
    char_valid = 1;
    char_data = 8'h5A;
    #1 check("clr_blocks_ready", int'(char_ready), 0);
    push_screen();
    @(posedge clk);
    #1 clear_req = 0;
    begin
      int n = 0;
      @(negedge clk);
      check("clr_busy", int'(busy), 1);
      while (!char_ready && n < 8000) begin @(negedge clk); n++; end
      chk_cursor("clr_home", 0, 0);
      model(8'h5A);
      @(posedge clk);
      #1 char_valid = 0;
    end
    wait_idle();
    chk_cursor("after_z", 1, 0);
    send(8'h0A, t);
    repeat (3) @(negedge clk);
    clear_req = 1;
    @(negedge clk);
    clear_req = 0;
    repeat (4) @(negedge clk);
    clear_req = 1;
    @(negedge clk);
    clear_req = 0;
    push_screen();
    wait_idle();
    chk_cursor("pend_clr", 0, 0);
    send(8'h0A, t);
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1 check("arst_we", int'(framebuffer_write_enable), 0);
    check("arst_busy", int'(busy), 1);
    q.delete();
    push_screen();
    @(negedge clk);
    rst_n = 1;
    wait_idle();
    chk_cursor("rerst", 0, 0);
    send(8'h51, t);
    wait_idle();
    chk_cursor("final", 1, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
